// File: rtl/rvdff_arb_stage_pkg.sv
// Shared widths and entry layout for the arbitrated 64-bit staging buffer.
// The top module derives its own widths from its parameters; these are the defaults.
package rvdff_arb_stage_pkg;
  localparam int ARB_WIDTH = 64;
  localparam int ARB_DEPTH = 2;
  localparam int ARB_NREQ  = 2;
  localparam int ARB_PTR_W = $clog2(ARB_DEPTH);
  localparam int ARB_SRC_W = $clog2(ARB_NREQ);

  typedef struct packed {
    logic [ARB_SRC_W-1:0] src;
    logic [ARB_WIDTH-1:0] data;
  } entry_t;
endpackage

// File: rtl/rvdff_arb_stage_if.sv
// Requester-side and consumer-side handshake bundle of the staging buffer.
interface rvdff_arb_stage_if #(
  parameter int WIDTH = rvdff_arb_stage_pkg::ARB_WIDTH,
  parameter int NREQ  = rvdff_arb_stage_pkg::ARB_NREQ,
  parameter int SRC_W = $clog2(NREQ)
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [SRC_W-1:0]           out_src;
  logic                       out_ready;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rvdffe_sync.sv
// Enabled register with synchronous active-high clear.
module rvdffe_sync #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_d, q_q;

  always_comb q_d = en ? d : q_q;

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/rvdff_arb_stage.sv
// Round-robin arbiter feeding a DEPTH-entry register FIFO drained over valid/ready.
// Outputs come straight from entry flops; ready depends on count only (no pop bypass).
module rvdff_arb_stage
  import rvdff_arb_stage_pkg::*;
#(
  parameter int WIDTH = ARB_WIDTH,
  parameter int DEPTH = ARB_DEPTH,
  parameter int NREQ  = ARB_NREQ
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  rvdff_arb_stage_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(NREQ);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [SW-1:0]    src;
    logic [WIDTH-1:0] data;
  } ent_t;

  logic [PW:0]   count_d, count_q;
  logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [SW-1:0] rr_ptr_d, rr_ptr_q;

  logic             found, push, pop;
  logic [SW-1:0]    grant, idx;
  logic [WIDTH-1:0] push_data;
  ent_t [DEPTH-1:0] entry_q;

  // Arbiter: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = SW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    push_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (SW'(i) == grant) push_data = bus.req_data[i];
  end

  always_comb begin
    push = found && (count_q < FULL) && !flush && !rst;
    pop  = bus.out_valid && bus.out_ready && !flush;
    bus.req_ready = '0;
    if (push) bus.req_ready[grant] = 1'b1;

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_ptr_d = rr_ptr_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_ptr_d = (int'(grant) == NREQ-1) ? '0 : grant + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rvdffe_sync #(.WIDTH(SW+WIDTH)) u_ent (
      .clk (clk),
      .rst (rst),
      .en  (push && (wr_ptr_q == PW'(e))),
      .d   ({grant, push_data}),
      .q   (entry_q[e])
    );
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = entry_q[rd_ptr_q].data;
  assign bus.out_src   = entry_q[rd_ptr_q].src;
endmodule

// File: tb/tb_rvdff_arb_stage.sv
// Directed vector bench for rvdff_arb_stage (WIDTH=64, DEPTH=2, NREQ=2).
module tb_rvdff_arb_stage;
  logic clk = 1'b0;
  logic rst, flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rvdff_arb_stage_if #(.WIDTH(64), .NREQ(2)) bus ();

  rvdff_arb_stage #(.WIDTH(64), .DEPTH(2), .NREQ(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [1:0]  rv;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        ordy;
    logic [1:0]  e_rdy;
    logic        e_vld;
    logic [63:0] e_data;
    logic        e_src;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic [1:0] rv,
                     input logic [63:0] d0, input logic [63:0] d1, input logic ordy,
                     input logic [1:0] e_rdy, input logic e_vld,
                     input logic [63:0] e_data, input logic e_src);
    vec_t v;
    v.rst = r; v.flush = f; v.rv = rv; v.d0 = d0; v.d1 = d1; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_src = e_src;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Initial reset, requesters asserting throughout
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 2'b11; bus.req_data[0] = 64'h0; bus.req_data[1] = 64'h0;
    bus.out_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready_c0", 64'(bus.req_ready), 64'h0);
    @(negedge clk); #1;
    chk("rst_ready_c1", 64'(bus.req_ready), 64'h0);
    chk("rst_valid_c1", 64'(bus.out_valid), 64'h0);

    //  rst f  rv     d0                     d1     or  e_rdy e_vld e_data                 e_src
    add(0, 0, 2'b00, 64'h0,                 64'h0,  0, 2'b00, 0, 64'h0,                 0); // T0
    add(0, 0, 2'b01, 64'hDEAD_BEEF_0000_0001, 64'h0, 1, 2'b01, 0, 64'h0,                 0); // single push
    add(0, 0, 2'b00, 64'h0,                 64'h0,  1, 2'b00, 1, 64'hDEAD_BEEF_0000_0001, 0);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  0, 2'b00, 0, 64'h0,                 0);
    add(0, 0, 2'b11, 64'hA,                 64'hB,  1, 2'b10, 0, 64'h0,                 0); // round robin
    add(0, 0, 2'b11, 64'hA,                 64'hB,  1, 2'b01, 1, 64'hB,                 1);
    add(0, 0, 2'b11, 64'hA,                 64'hB,  1, 2'b10, 1, 64'hA,                 0);
    add(0, 0, 2'b11, 64'hA,                 64'hB,  1, 2'b01, 1, 64'hB,                 1);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  1, 2'b00, 1, 64'hA,                 0);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  0, 2'b00, 0, 64'hB,                 1);
    add(0, 0, 2'b01, 64'h1,                 64'h0,  0, 2'b01, 0, 64'hB,                 1); // backpressure
    add(0, 0, 2'b01, 64'h2,                 64'h0,  0, 2'b01, 1, 64'h1,                 0);
    add(0, 0, 2'b01, 64'h3,                 64'h0,  0, 2'b00, 1, 64'h1,                 0);
    add(0, 0, 2'b01, 64'h3,                 64'h0,  1, 2'b00, 1, 64'h1,                 0); // full: no bypass
    add(0, 0, 2'b01, 64'h3,                 64'h0,  0, 2'b01, 1, 64'h2,                 0);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  1, 2'b00, 1, 64'h2,                 0);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  1, 2'b00, 1, 64'h3,                 0);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  0, 2'b00, 0, 64'h2,                 0);
    add(0, 0, 2'b01, 64'h10,                64'h0,  0, 2'b01, 0, 64'h2,                 0); // count -> 1
    for (int k = 0; k < 8; k++)                                                           // push+pop at count 1
      add(0, 0, 2'b01, 64'h11 + 64'(k),     64'h0,  1, 2'b01, 1, 64'h10 + 64'(k),       0);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  1, 2'b00, 1, 64'h18,                0);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  0, 2'b00, 0, 64'h17,                0);
    add(0, 0, 2'b11, 64'h20,                64'h21, 0, 2'b10, 0, 64'h17,                0); // fill for flush
    add(0, 0, 2'b01, 64'h22,                64'h0,  0, 2'b01, 1, 64'h21,                1);
    add(0, 1, 2'b10, 64'h0,                 64'h23, 1, 2'b00, 1, 64'h21,                1); // flush
    add(0, 0, 2'b00, 64'h0,                 64'h0,  0, 2'b00, 0, 64'h22,                0);
    add(0, 0, 2'b11, 64'h30,                64'h31, 0, 2'b10, 0, 64'h22,                0); // rr kept
    add(0, 0, 2'b00, 64'h0,                 64'h0,  1, 2'b00, 1, 64'h31,                1);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  0, 2'b00, 0, 64'h21,                1);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  1, 2'b00, 0, 64'h21,                1); // pop on empty
    add(0, 0, 2'b01, 64'h40,                64'h0,  0, 2'b01, 0, 64'h21,                1);
    add(1, 1, 2'b11, 64'h41,                64'h42, 1, 2'b00, 1, 64'h40,                0); // mid-op reset
    add(0, 0, 2'b11, 64'h50,                64'h51, 0, 2'b01, 0, 64'h0,                 0);
    add(0, 0, 2'b00, 64'h0,                 64'h0,  0, 2'b00, 1, 64'h50,                0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush;
      bus.req_valid = vecs[i].rv;
      bus.req_data[0] = vecs[i].d0; bus.req_data[1] = vecs[i].d1;
      bus.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_data", i),  bus.out_data,       vecs[i].e_data);
      chk($sformatf("v%0d_src", i),   64'(bus.out_src),   64'(vecs[i].e_src));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
